// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings ({cs_n,ras_n,cas_n,we_n}) and arbiter state type.
package sdram_pkg;

  localparam logic [3:0] NOP         = 4'b0111;
  localparam logic [3:0] PRECHARGE   = 4'b0010;
  localparam logic [3:0] REFRESH     = 4'b0001;
  localparam logic [3:0] MODEREG_SET = 4'b0000;
  localparam logic [3:0] ACTIVE      = 4'b0011;
  localparam logic [3:0] WRITE       = 4'b0100;
  localparam logic [3:0] READ        = 4'b0101;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_aref_timer.sv
// Periodic auto-refresh request generator; a wrap on the same edge as clr keeps the request set.
module sdram_aref_timer #(
  parameter int AREF_PERIOD = 750,
  parameter int CNT_W       = 10
) (
  input  logic sysclk_100M,
  input  logic rst_n,
  input  logic enable,
  input  logic clr,
  output logic aref_req
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = enable && (cnt == CNT_W'(AREF_PERIOD - 1));

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      aref_req <= 1'b0;
    end else begin
      if (enable) begin
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
      end
      if (wrap) begin
        aref_req <= 1'b1;
      end else if (clr) begin
        aref_req <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command scheduler: init pass-through, then refresh > write > read grants onto the bus.
// Define SDRAM_ARB_RR_EN to alternate write/read grants when both are requesting.
module sdram_arbiter #(
  parameter int AREF_PERIOD = 750,
  parameter int CNT_W       = 10
) (
  input  logic        sysclk_100M,
  input  logic        rst_n,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic        init_end_flag,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [12:0] aref_addr,
  input  logic        aref_end,
  input  logic        wr_req,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic        wr_end,
  input  logic        rd_req,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  input  logic        rd_end,
  output logic        aref_req,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr
);

  import sdram_pkg::*;

  arb_state_t state;
  logic       timer_en;
  logic       aref_clr;
  logic       grant_wr;
  logic       grant_rd;

  // Once out of INIT the timer keeps running even if init_end_flag later drops.
  assign timer_en = init_end_flag || (state != ST_INIT);
  assign aref_clr = (state == ST_ARBIT) && aref_req;

  sdram_aref_timer #(
    .AREF_PERIOD(AREF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_aref_timer (
    .sysclk_100M(sysclk_100M),
    .rst_n      (rst_n),
    .enable     (timer_en),
    .clr        (aref_clr),
    .aref_req   (aref_req)
  );

`ifdef SDRAM_ARB_RR_EN
  logic last_wr;

  always_comb begin
    grant_wr = wr_req && (!rd_req || !last_wr);
    grant_rd = rd_req && !grant_wr;
  end
`else
  always_comb begin
    grant_wr = wr_req;
    grant_rd = rd_req && !wr_req;
  end
`endif

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_wr <= 1'b0;
`endif
    end else begin
      case (state)
        ST_INIT: begin
          if (init_end_flag) begin
            state <= ST_ARBIT;
          end
        end
        ST_ARBIT: begin
          if (aref_req) begin
            state   <= ST_AREF;
            aref_en <= 1'b1;
          end else if (grant_wr) begin
            state <= ST_WRITE;
            wr_en <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
            last_wr <= 1'b1;
`endif
          end else if (grant_rd) begin
            state <= ST_READ;
            rd_en <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
            last_wr <= 1'b0;
`endif
          end
        end
        // Each grant always returns through ARBIT, giving one NOP cycle between grants.
        ST_AREF: begin
          if (aref_end) begin
            state   <= ST_ARBIT;
            aref_en <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (wr_end) begin
            state <= ST_ARBIT;
            wr_en <= 1'b0;
          end
        end
        ST_READ: begin
          if (rd_end) begin
            state <= ST_ARBIT;
            rd_en <= 1'b0;
          end
        end
        default: begin
          state   <= ST_INIT;
          aref_en <= 1'b0;
          wr_en   <= 1'b0;
          rd_en   <= 1'b0;
        end
      endcase
    end
  end

  // Bus is forced to NOP while reset is held, since INIT would otherwise pass init_* through.
  always_comb begin
    sdram_cmd  = NOP;
    sdram_ba   = 2'b00;
    sdram_addr = 13'd0;
    if (rst_n) begin
      case (state)
        ST_INIT: begin
          sdram_cmd  = init_cmd;
          sdram_ba   = init_ba;
          sdram_addr = init_addr;
        end
        ST_AREF: begin
          sdram_cmd  = aref_cmd;
          sdram_ba   = aref_ba;
          sdram_addr = aref_addr;
        end
        ST_WRITE: begin
          sdram_cmd  = wr_cmd;
          sdram_ba   = wr_ba;
          sdram_addr = wr_addr;
        end
        ST_READ: begin
          sdram_cmd  = rd_cmd;
          sdram_ba   = rd_ba;
          sdram_addr = rd_addr;
        end
        default: begin
          sdram_cmd  = NOP;
          sdram_ba   = 2'b00;
          sdram_addr = 13'd0;
        end
      endcase
    end
  end

endmodule
